uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 16x-oversampled serial frame (start, data LSB first, stop).
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned N_DATA_BITS = 8,
    parameter int unsigned SB_TICK     = 16,
    parameter int unsigned BAUD_DIV    = 163
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_tx_start,
    input  logic [N_DATA_BITS-1:0] i_data,
    output logic                   o_tx,
    output logic                   o_tx_done,
    output logic                   o_busy
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned IDX_W = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       S_LAST    = 4'd15;
    localparam logic [3:0]       STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [IDX_W-1:0] N_LAST    = IDX_W'(N_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [CNT_W-1:0]       r_baud_cnt;
    logic                   w_tick;
    state_t                 r_state, w_state_next;
    logic [3:0]             r_s, w_s_next;
    logic [IDX_W-1:0]       r_n, w_n_next;
    logic [N_DATA_BITS-1:0] r_shift, w_shift_next;
    logic                   w_tx_next, w_done_next, w_busy_next;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity, w_parity_next;
`endif

    // Free-running oversample tick, independent of frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

    assign w_tick = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_shift   <= '0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
            o_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_n       <= w_n_next;
            r_shift   <= w_shift_next;
            o_tx      <= w_tx_next;
            o_tx_done <= w_done_next;
            o_busy    <= w_busy_next;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_s_next      = r_s;
        w_n_next      = r_n;
        w_shift_next  = r_shift;
        w_done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (i_tx_start) begin
                    w_shift_next  = i_data;
                    w_s_next      = '0;
                    w_state_next  = START;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^i_data;
`endif
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        w_n_next     = r_n + IDX_W'(1);
                        if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = PARITY;
`else
                            w_state_next = STOP;
`endif
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_state_next = STOP;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level is decoded from the next state so o_tx lines up with the state register
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != IDLE);
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with BAUD_DIV=4 (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB       = 11;
    localparam int DONE_NOM = 704;
    localparam logic [10:0] SEQ_A5 = 11'b01010010101;
    localparam logic [10:0] SEQ_07 = 11'b01110000011;
    localparam logic [10:0] SEQ_3C = 11'b00011110001;
    localparam logic [10:0] SEQ_55 = 11'b01010101001;
    localparam logic [10:0] SEQ_81 = 11'b01000000101;
    localparam logic [10:0] SEQ_00 = 11'b00000000001;
`else
    localparam int NB       = 10;
    localparam int DONE_NOM = 640;
    localparam logic [10:0] SEQ_A5 = 11'b0101001011;
    localparam logic [10:0] SEQ_07 = 11'b0111000001;
    localparam logic [10:0] SEQ_3C = 11'b0001111001;
    localparam logic [10:0] SEQ_55 = 11'b0101010101;
    localparam logic [10:0] SEQ_81 = 11'b0100000011;
    localparam logic [10:0] SEQ_00 = 11'b0000000001;
`endif

    logic       clk;
    logic       rst;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(
        .N_DATA_BITS(8),
        .SB_TICK    (16),
        .BAUD_DIV   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_tx_start(i_tx_start),
        .i_data    (i_data),
        .o_tx      (o_tx),
        .o_tx_done (o_tx_done),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the first negedge after the accepting edge
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        i_data     = d;
        i_tx_start = 1'b1;
        @(negedge clk);
        i_tx_start = 1'b0;
    endtask

    // Sample each bit mid-level, optionally poke inputs at cycle inj_cyc, chain a 0x55 start on done
    task automatic frame(input string tag, input logic [10:0] seq, input int inj_cyc,
                         input logic inj_start, input logic [7:0] inj_data, input logic b2b,
                         output int done_at, output int done_cnt);
        done_at  = -1;
        done_cnt = 0;
        for (int cyc = 1; cyc <= NB * 64 + 40; cyc++) begin
            @(negedge clk);
            if (cyc == inj_cyc) begin
                i_data     = inj_data;
                i_tx_start = inj_start;
            end else if (cyc == inj_cyc + 1) begin
                i_tx_start = 1'b0;
            end
            if (cyc == 32)
                check($sformatf("%s busy", tag), 32'(o_busy), 32'd1);
            if ((cyc % 64) == 32 && (cyc / 64) < NB)
                check($sformatf("%s bit%0d", tag, cyc / 64), 32'(o_tx), 32'(seq[NB - 1 - cyc / 64]));
            if (o_tx_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
                if (b2b) begin
                    i_data     = 8'h55;
                    i_tx_start = 1'b1;
                    @(negedge clk);
                    i_tx_start = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic end_checks(input string tag, input int done_at, input int done_cnt);
        check($sformatf("%s done count", tag), 32'(done_cnt), 32'd1);
        check($sformatf("%s done time %0d", tag, done_at),
              32'(done_at >= DONE_NOM - 4 && done_at <= DONE_NOM + 4), 32'd1);
        check($sformatf("%s idle tx", tag), 32'(o_tx), 32'd1);
        check($sformatf("%s idle busy", tag), 32'(o_busy), 32'd0);
    endtask

    initial begin
        int da, dc, nd;
        rst        = 1'b1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        #12;
        check("rst tx", 32'(o_tx), 32'd1);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_tx_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send(8'hA5);
        frame("a5", SEQ_A5, -1, 1'b0, 8'h00, 1'b0, da, dc);
        end_checks("a5", da, dc);

        send(8'h07);
        frame("07", SEQ_07, -1, 1'b0, 8'h00, 1'b0, da, dc);
        end_checks("07", da, dc);

        send(8'h3C);
        frame("busy", SEQ_3C, 100, 1'b1, 8'hFF, 1'b0, da, dc);
        end_checks("busy", da, dc);

        send(8'hA5);
        frame("b2b1", SEQ_A5, -1, 1'b0, 8'h00, 1'b1, da, dc);
        check("b2b1 done count", 32'(dc), 32'd1);
        check("b2b no gap tx", 32'(o_tx), 32'd0);
        check("b2b no gap busy", 32'(o_busy), 32'd1);
        frame("b2b2", SEQ_55, -1, 1'b0, 8'h00, 1'b0, da, dc);
        end_checks("b2b2", da, dc);

        send(8'h81);
        frame("hold", SEQ_81, 1, 1'b0, 8'h18, 1'b0, da, dc);
        end_checks("hold", da, dc);

        send(8'h00);
        repeat (299) @(negedge clk);
        check("mid tx before rst", 32'(o_tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid rst tx", 32'(o_tx), 32'd1);
        check("mid rst busy", 32'(o_busy), 32'd0);
        check("mid rst done", 32'(o_tx_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (o_tx_done) nd++;
        end
        check("mid no done", 32'(nd), 32'd0);
        check("mid idle tx", 32'(o_tx), 32'd1);

        send(8'h00);
        frame("post", SEQ_00, -1, 1'b0, 8'h00, 1'b0, da, dc);
        end_checks("post", da, dc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
